// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: memory-side responder for the core's fetch and load/store
// strobes. It holds a 2^MEM_WORDS_LOG2 x 32 word array with separate inst and
// data channels. Each channel answers one request per LATENCY cycles with a
// single-cycle valid pulse.
//
// Ports
//   clk, rst            rising-edge clock, async active-low reset
//   inst_fetch/addr     fetch strobe and byte address
//   inst_data/valid     fetched word and one-cycle response pulse
//   load_data/store_data load/store strobes (store wins if both are high)
//   data_addr/wdata/wstrb byte address, store data, byte enables
//   data_rdata/valid    load data and one-cycle completion pulse
//   protocol_err        sticky flag: dropped strobe or load+store collision

// Per-channel sequencer: IDLE -> (WAIT)* -> RESP. The address/data capture is
// left to the parent. fire_o marks the edge that enters RESP, which is where
// the array access happens.
module mem_responder_chan #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic accept_o,
  output logic drop_o,
  output logic fire_o,
  output logic valid_o
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == S_RESP);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        // Counter holds the WAIT cycles still to go, so the last WAIT cycle
        // is the one where it reads 1.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      default: begin
        // IDLE and RESP both accept a new request.
        state_d = S_IDLE;
        if (req_i) begin
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
    endcase
  end

  always_comb begin
    accept_o = req_i && (state_q != S_WAIT);
    drop_o   = req_i && (state_q == S_WAIT);
    fire_o   = (state_d == S_RESP);
  end

  assign valid_o = valid_q;
endmodule

module mem_responder #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int INST_LATENCY   = 1,
  parameter int DATA_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_fetch,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_valid,
  input  logic        load_data,
  input  logic        store_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        protocol_err
);
  localparam int AW     = MEM_WORDS_LOG2;
  localparam int DEPTH  = 1 << AW;
  localparam int NUM_CH = 2;  // 0 = inst, 1 = data

  if (INST_LATENCY < 1) begin : g_bad_inst_lat
    $error("INST_LATENCY must be >= 1");
  end
  if (DATA_LATENCY < 1) begin : g_bad_data_lat
    $error("DATA_LATENCY must be >= 1");
  end

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          store;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } dreq_t;

  logic [NUM_CH-1:0] ch_req, ch_accept, ch_drop, ch_fire, ch_valid;

  assign ch_req = {load_data | store_data, inst_fetch};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mem_responder_chan #(
      .LATENCY((g == 0) ? INST_LATENCY : DATA_LATENCY)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .req_i    (ch_req[g]),
      .accept_o (ch_accept[g]),
      .drop_o   (ch_drop[g]),
      .fire_o   (ch_fire[g]),
      .valid_o  (ch_valid[g])
    );
  end

  // Request capture. With LATENCY=1 the access happens on the same edge the
  // request is accepted, so the live inputs bypass the capture register.
  logic [AW-1:0] inst_idx_q, inst_idx_eff;
  dreq_t         dreq_q, dreq_in, dreq_eff;

  always_comb begin
    dreq_in.idx   = data_addr[AW+1:2];
    dreq_in.store = store_data;
    dreq_in.wdata = data_wdata;
    dreq_in.wstrb = data_wstrb;
  end

  assign inst_idx_eff = ch_accept[0] ? inst_addr[AW+1:2] : inst_idx_q;
  assign dreq_eff     = ch_accept[1] ? dreq_in : dreq_q;

  always_ff @(posedge clk) begin
    if (ch_accept[0]) inst_idx_q <= inst_addr[AW+1:2];
    if (ch_accept[1]) dreq_q     <= dreq_in;
  end

  // Word array, not reset. Writes are gated by rst so a strobe seen while
  // reset is held cannot touch memory.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst && ch_fire[1] && dreq_eff.store) begin
      for (int b = 0; b < 4; b++) begin
        if (dreq_eff.wstrb[b]) mem_q[dreq_eff.idx][8*b +: 8] <= dreq_eff.wdata[8*b +: 8];
      end
    end
  end

  // Read data registers. Non-blocking reads see the pre-write word when a
  // fetch and a store to the same word land on one edge.
  logic [31:0] inst_data_q, data_rdata_q;
  logic        err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_data_q  <= '0;
      data_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (ch_fire[0]) inst_data_q <= mem_q[inst_idx_eff];
      if (ch_fire[1] && !dreq_eff.store) data_rdata_q <= mem_q[dreq_eff.idx];
      if ((|ch_drop) || (load_data && store_data)) err_q <= 1'b1;
    end
  end

  assign inst_data    = inst_data_q;
  assign inst_valid   = ch_valid[0];
  assign data_rdata   = data_rdata_q;
  assign data_valid   = ch_valid[1];
  assign protocol_err = err_q;

  // Byte offset and upper address bits are ignored (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:AW+2], inst_addr[1:0],
                              data_addr[31:AW+2], data_addr[1:0]};
endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int IL0 = 1, DL0 = 1;  // instance 0
  localparam int IL1 = 4, DL1 = 3;  // instance 1

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_fetch, load_data, store_data;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;

  logic [31:0] inst_data  [2];
  logic        inst_valid [2];
  logic [31:0] data_rdata [2];
  logic        data_valid [2];
  logic        protocol_err [2];

  always #5 clk = ~clk;

  mem_responder #(.MEM_WORDS_LOG2(AW), .INST_LATENCY(IL0), .DATA_LATENCY(DL0)) u0 (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch), .inst_addr(inst_addr),
    .inst_data(inst_data[0]), .inst_valid(inst_valid[0]),
    .load_data(load_data), .store_data(store_data),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_rdata(data_rdata[0]), .data_valid(data_valid[0]),
    .protocol_err(protocol_err[0])
  );

  mem_responder #(.MEM_WORDS_LOG2(AW), .INST_LATENCY(IL1), .DATA_LATENCY(DL1)) u1 (
    .clk(clk), .rst(rst),
    .inst_fetch(inst_fetch), .inst_addr(inst_addr),
    .inst_data(inst_data[1]), .inst_valid(inst_valid[1]),
    .load_data(load_data), .store_data(store_data),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_rdata(data_rdata[1]), .data_valid(data_valid[1]),
    .protocol_err(protocol_err[1])
  );

  // Reference model: per instance, a word array plus the cycle at which the
  // outstanding request of each channel is due (-1 = none).
  int          n_assert, n_fail, cyc;
  logic [31:0] mm [2][DEPTH];
  int          idue [2], ddue [2], iw [2], dw [2];
  bit          dst [2];
  logic [31:0] dwd [2];
  logic [3:0]  dws [2];
  bit          eiv [2], edv [2], eerr [2];
  logic [31:0] eid [2], edd [2];

  function automatic int il(int k); return (k == 0) ? IL0 : IL1; endfunction
  function automatic int dl(int k); return (k == 0) ? DL0 : DL1; endfunction
  function automatic int widx(logic [31:0] a); return int'((a / 4) % DEPTH); endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      idue[k] = -1; ddue[k] = -1;
      eiv[k] = 0; edv[k] = 0; eerr[k] = 0;
      eid[k] = '0; edd[k] = '0;
    end
  endtask

  task automatic model_edge(int k);
    int co, cn;
    co = cyc - 1; cn = cyc;
    eiv[k] = 0; edv[k] = 0;
    if (!rst) return;
    if (load_data && store_data) eerr[k] = 1;
    if (inst_fetch) begin
      if (idue[k] > co) eerr[k] = 1;
      else begin idue[k] = co + il(k); iw[k] = widx(inst_addr); end
    end
    if (load_data || store_data) begin
      if (ddue[k] > co) eerr[k] = 1;
      else begin
        ddue[k] = co + dl(k); dw[k] = widx(data_addr);
        dst[k] = store_data; dwd[k] = data_wdata; dws[k] = data_wstrb;
      end
    end
    // Reads first, so a same-edge store is not visible to the fetch.
    if (idue[k] == cn) begin eiv[k] = 1; eid[k] = mm[k][iw[k]]; end
    if (ddue[k] == cn) begin
      edv[k] = 1;
      if (!dst[k]) edd[k] = mm[k][dw[k]];
      else for (int b = 0; b < 4; b++)
        if (dws[k][b]) mm[k][dw[k]][8*b +: 8] = dwd[k][8*b +: 8];
    end
  endtask

  task automatic chk(string tag, int k, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s u%0d: got %08h want %08h (cycle %0d)", tag, k, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("inst_valid",   k, {31'd0, inst_valid[k]},   {31'd0, eiv[k]});
      chk("inst_data",    k, inst_data[k],             eid[k]);
      chk("data_valid",   k, {31'd0, data_valid[k]},   {31'd0, edv[k]});
      chk("data_rdata",   k, data_rdata[k],            edd[k]);
      chk("protocol_err", k, {31'd0, protocol_err[k]}, {31'd0, eerr[k]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    inst_fetch = 0; load_data = 0; store_data = 0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
  endtask

  task automatic idle(int n); repeat (n) step(); endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    store_data = 1; data_addr = a; data_wdata = d; data_wstrb = s;
    step();
    store_data = 0;
  endtask

  task automatic rd(logic [31:0] a);
    load_data = 1; data_addr = a;
    step();
    load_data = 0;
  endtask

  task automatic fetch(logic [31:0] a);
    inst_fetch = 1; inst_addr = a;
    step();
    inst_fetch = 0;
  endtask

  // Called mid-cycle: asserts reset asynchronously, checks outputs clear at
  // once, holds for two edges and releases away from the clock edge.
  task automatic do_reset();
    idle_inputs();
    rst = 0;
    #1;
    mreset();
    check_all();
    step(); step();
    #1 rst = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old5;
    int r;
    n_assert = 0; n_fail = 0; cyc = 0;
    rst = 0;
    idle_inputs();
    mreset();
    step(); step();
    #1 rst = 1;

    // Preload words 0..31 through the store port.
    for (int w = 0; w < 32; w++) begin
      wr(32'(w * 4), $urandom, 4'hF); idle(3);
    end
    wr(32'h0, 32'hCAFEF00D, 4'hF);  idle(3);
    wr(32'h0C, 32'hDEADBEEF, 4'hF); idle(3);
    wr(32'h40, 32'hAABBCCDD, 4'hF); idle(3);

    // Fetch word 3: latency-1 instance answers on the next cycle only.
    fetch(32'h0C);
    chk("fetch_deadbeef", 0, inst_data[0], 32'hDEADBEEF);
    chk("fetch_valid", 0, {31'd0, inst_valid[0]}, 32'd1);
    idle(4);

    // Masked store then load.
    wr(32'h40, 32'h11223344, 4'b0101); idle(3);
    rd(32'h40);
    chk("load_merge", 0, data_rdata[0], 32'hAA22CC44);
    idle(2);
    chk("load_merge", 1, data_rdata[1], 32'hAA22CC44);
    idle(2);

    // Back-to-back loads: the second strobe lands in u1's WAIT and is dropped.
    rd(32'h0C);
    rd(32'h40);
    chk("drop_err", 1, {31'd0, protocol_err[1]}, 32'd1);
    chk("no_err",   0, {31'd0, protocol_err[0]}, 32'd0);
    idle(1);
    rd(32'h40);
    idle(4);

    // Load+store collision is a store and flags an error.
    do_reset();
    load_data = 1; store_data = 1;
    data_addr = 32'h20; data_wdata = 32'h0BADF00D; data_wstrb = 4'hF;
    step();
    idle_inputs();
    chk("collide_err", 0, {31'd0, protocol_err[0]}, 32'd1);
    idle(3);
    rd(32'h20);
    chk("collide_store", 0, data_rdata[0], 32'h0BADF00D);
    idle(3);

    // Fetch and store to the same word on the same edge: fetch sees old data.
    do_reset();
    old5 = mm[0][5];
    inst_fetch = 1; inst_addr = 32'h14;
    store_data = 1; data_addr = 32'h14; data_wdata = 32'h12345678; data_wstrb = 4'hF;
    step();
    idle_inputs();
    chk("same_edge_old", 0, inst_data[0], old5);
    idle(4);
    fetch(32'h14);
    chk("same_edge_new", 0, inst_data[0], 32'h12345678);
    idle(4);

    // Address wrap and byte offset ignored.
    fetch(32'h1003);
    chk("wrap", 0, inst_data[0], 32'hCAFEF00D);
    idle(4);

    // Reset two cycles after a latency-4 fetch: never answered.
    load_data = 1; store_data = 1; data_addr = 32'h20; data_wdata = 32'h0BADF00D; data_wstrb = 4'hF;
    step();
    idle_inputs();
    idle(3);
    fetch(32'h0C);
    idle(1);
    do_reset();
    chk("rst_err_clr", 1, {31'd0, protocol_err[1]}, 32'd0);
    idle(6);
    fetch(32'h0C);
    idle(3);
    chk("mem_kept", 1, inst_data[1], 32'hDEADBEEF);
    chk("mem_kept_v", 1, {31'd0, inst_valid[1]}, 32'd1);
    idle(2);

    // Randomized traffic over the preloaded words, with aliased upper bits.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      inst_fetch = ($urandom_range(0, 2) == 0);
      inst_addr  = 32'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 7) << 12));
      r = int'($urandom_range(0, 15));
      load_data  = (r < 4) || (r == 8);
      store_data = (r >= 4 && r < 7) || (r == 8);
      data_addr  = 32'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 7) << 12));
      data_wdata = $urandom;
      data_wstrb = 4'($urandom_range(0, 15));
      step();
    end
    idle_inputs();
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
